regfile_scoreboard: RTL

Parametrised integer register file for the pipelined RISC-V core, with a per-register busy scoreboard for in-flight writebacks. Two combinational read ports with same-cycle writeback bypass, one write port, one issue port that marks destinations pending, and a flush input for branch/exception recovery. It sits between decode (read, issue), hazard control (busy flags) and writeback (write port).

---
 rtl/regfile_scoreboard_if.sv | 49 ++++
 rtl/regfile_scoreboard.sv | 112 +++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard_if
// Description : Bundle of the register file / scoreboard signals shared by
//               decode, hazard control and writeback.
//               master : client side (drives addresses, write, issue, flush;
//                        receives read data, busy flags and busy count)
//               slave  : register file side
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);

  // Read ports
  logic [AW-1:0]   rd_addr1;
  logic [AW-1:0]   rd_addr2;
  logic [XLEN-1:0] rd_data1;
  logic [XLEN-1:0] rd_data2;
  logic            rd_busy1;
  logic            rd_busy2;

  // Write-back port
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  // Issue / recovery
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic            flush;

  // Scoreboard occupancy
  logic [AW:0]     busy_cnt;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
  );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Integer register file with per-register busy scoreboard.
//               Two combinational read ports with same-cycle writeback
//               bypass, one write port, one issue port marking destinations
//               pending, and a flush that drops every pending producer.
// Ports       : clk  - clock, all state changes on rising edge
//               rst  - synchronous active-high reset
//               bus  - regfile_scoreboard_if.slave (read/write/issue/flush,
//                      read data, busy flags, busy_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  wire logic               clk,
  input  wire logic               rst,
  regfile_scoreboard_if.slave     bus
);

  localparam logic [AW-1:0] c_X0 = '0;

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;

  logic             w_wr_valid;
  logic             w_iss_valid;
  logic             w_cnt_inc;
  logic             w_cnt_dec;
  logic [AW:0]      w_cnt_next;

  // x0 is hardwired, so writes/issues targeting it are dropped here once.
  // Flush suppresses a same-cycle issue but not a same-cycle write.
  assign w_wr_valid  = bus.wr_en  && (bus.wr_addr  != c_X0);
  assign w_iss_valid = bus.iss_en && (bus.iss_addr != c_X0) && !bus.flush;

  // Incremental occupancy tracking. An issue adds one only if the target was
  // idle. A writeback removes one only if the target was busy and is not
  // being re-claimed by a same-cycle issue (the new producer keeps it busy).
  assign w_cnt_inc  = w_iss_valid && !r_busy[bus.iss_addr];
  assign w_cnt_dec  = w_wr_valid && r_busy[bus.wr_addr] &&
                      !(w_iss_valid && (bus.iss_addr == bus.wr_addr));
  assign w_cnt_next = r_busy_cnt + {{AW{1'b0}}, w_cnt_inc}
                                 - {{AW{1'b0}}, w_cnt_dec};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr_valid) begin
        r_regs[bus.wr_addr] <= bus.wr_data;
      end
      if (bus.flush) begin
        r_busy     <= '0;
        r_busy_cnt <= '0;
      end else begin
        // Issue is applied after the writeback clear so that an issue and
        // writeback to the same register leaves the bit set.
        if (w_wr_valid) begin
          r_busy[bus.wr_addr] <= 1'b0;
        end
        if (w_iss_valid) begin
          r_busy[bus.iss_addr] <= 1'b1;
        end
        r_busy_cnt <= w_cnt_next;
      end
    end
  end

  // Read port 1: writeback bypass makes the value being written visible in
  // the same cycle and hides the busy flag it is about to clear.
  always_comb begin
    bus.rd_data1 = '0;
    bus.rd_busy1 = 1'b0;
    if (bus.rd_addr1 != c_X0) begin
      if (w_wr_valid && (bus.wr_addr == bus.rd_addr1)) begin
        bus.rd_data1 = bus.wr_data;
        bus.rd_busy1 = 1'b0;
      end else begin
        bus.rd_data1 = r_regs[bus.rd_addr1];
        bus.rd_busy1 = r_busy[bus.rd_addr1];
      end
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    bus.rd_data2 = '0;
    bus.rd_busy2 = 1'b0;
    if (bus.rd_addr2 != c_X0) begin
      if (w_wr_valid && (bus.wr_addr == bus.rd_addr2)) begin
        bus.rd_data2 = bus.wr_data;
        bus.rd_busy2 = 1'b0;
      end else begin
        bus.rd_data2 = r_regs[bus.rd_addr2];
        bus.rd_busy2 = r_busy[bus.rd_addr2];
      end
    end
  end

  assign bus.busy_cnt = r_busy_cnt;

endmodule
`default_nettype wire
